// File: rtl/demux_pkg.sv
// demux_pkg: shared frame FSM encoding and parameter defaults for the demux frame driver
package demux_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;
  localparam int CLKS_PER_BIT_DEF = 4;
  localparam int DATA_W_DEF = 8;
endpackage

// File: rtl/bit_timer.sv
// bit_timer: counts CLKS_PER_BIT cycles while enabled and flags the last cycle of each bit period
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic bit_tick
);
  localparam int W = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  logic [W-1:0] cnt;
  assign bit_tick = en && cnt == LAST;
  // Idle clears the count so every frame starts on a full bit period
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (!en || bit_tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/demux_frame_driver.sv
// demux_frame_driver: serializes a word as start/data/stop bits onto a demux input
// while holding the demux channel select steady for the whole frame
module demux_frame_driver
  import demux_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_chan,
  output logic              demux_in,
  output logic [1:0]        demux_signal,
  output logic              busy,
  output logic              frame_done
);
  localparam int BW = $clog2(DATA_W) + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
  state_t state, state_n;
  logic [BW-1:0] bit_cnt, bit_cnt_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic tick;
  logic accept;
  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (state != IDLE),
    .bit_tick (tick)
  );
  assign in_ready = rst_n && state == IDLE;
  assign accept = in_valid && in_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    bit_cnt_n = bit_cnt;
    shreg_n = shreg;
    case (state)
      IDLE: if (accept) begin
        state_n = START;
        shreg_n = in_data;
        bit_cnt_n = '0;
      end
      START: if (tick) state_n = DATA;
      DATA: if (tick) begin
        state_n = bit_cnt == LAST_BIT ? STOP : DATA;
        bit_cnt_n = bit_cnt + 1'b1;
        shreg_n = shreg >> 1;
      end
      STOP: if (tick) state_n = IDLE;
    endcase
  end
  // Outputs are registered from the next state so the line changes on the same edge as the FSM
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bit_cnt <= '0;
      shreg <= '0;
      demux_in <= 1'b0;
      demux_signal <= 2'b00;
      busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      bit_cnt <= bit_cnt_n;
      shreg <= shreg_n;
      demux_in <= state_n == START || (state_n == DATA && shreg_n[0]);
      busy <= state_n != IDLE;
      frame_done <= state == STOP && state_n == IDLE;
      if (accept) demux_signal <= in_chan;
    end
endmodule

// File: tb/tb_demux_frame_driver.sv
// tb_demux_frame_driver: checks two drivers (4 and 1 clocks per bit) against a per-cycle frame model
module tb_demux_frame_driver;
  localparam int DW = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_valid [2];
  logic [DW-1:0] in_data [2];
  logic [1:0] in_chan [2];
  logic in_ready [2];
  logic demux_in [2];
  logic [1:0] demux_signal [2];
  logic busy [2];
  logic frame_done [2];
  int total = 0;
  int bad = 0;
  int pos [2];
  logic [DW-1:0] md [2];
  logic [1:0] mch [2];
  logic mdone [2];

  always #5 clk = ~clk;

  demux_frame_driver #(.CLKS_PER_BIT(4), .DATA_W(DW)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .in_chan(in_chan[0]), .demux_in(demux_in[0]),
    .demux_signal(demux_signal[0]), .busy(busy[0]), .frame_done(frame_done[0])
  );
  demux_frame_driver #(.CLKS_PER_BIT(1), .DATA_W(DW)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .in_chan(in_chan[1]), .demux_in(demux_in[1]),
    .demux_signal(demux_signal[1]), .busy(busy[1]), .frame_done(frame_done[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int cpb(input int k);
    return k == 0 ? 4 : 1;
  endfunction

  // Reference: a frame is start bit, DW data bits LSB first, stop bit, each cpb cycles long
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        check($sformatf("rst_ready%0d", k), in_ready[k], 0);
        check($sformatf("rst_din%0d", k), demux_in[k], 0);
        check($sformatf("rst_sig%0d", k), demux_signal[k], 0);
        check($sformatf("rst_busy%0d", k), busy[k], 0);
        check($sformatf("rst_done%0d", k), frame_done[k], 0);
        pos[k] = -1;
        mch[k] = 2'd0;
        mdone[k] = 1'b0;
      end else begin
        int idx;
        logic exp_din;
        idx = pos[k] / cpb(k);
        exp_din = pos[k] < 0 ? 1'b0 : idx == 0 ? 1'b1 : idx <= DW ? md[k][idx-1] : 1'b0;
        check($sformatf("ready%0d", k), in_ready[k], pos[k] < 0);
        check($sformatf("din%0d", k), demux_in[k], exp_din);
        check($sformatf("sig%0d", k), demux_signal[k], mch[k]);
        check($sformatf("busy%0d", k), busy[k], pos[k] >= 0);
        check($sformatf("done%0d", k), frame_done[k], mdone[k]);
        mdone[k] = 1'b0;
        if (pos[k] < 0) begin
          if (in_valid[k]) begin
            pos[k] = 0;
            md[k] = in_data[k];
            mch[k] = in_chan[k];
          end
        end else begin
          pos[k]++;
          if (pos[k] == (DW + 2) * cpb(k)) begin
            pos[k] = -1;
            mdone[k] = 1'b1;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b0;
      in_data[k] = '0;
      in_chan[k] = 2'd0;
      pos[k] = -1;
      md[k] = '0;
      mch[k] = 2'd0;
      mdone[k] = 1'b0;
    end
    #1 rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    // basic frame on the slow driver, fastest-rate frame on the fast one
    in_valid[0] = 1'b1; in_data[0] = 8'hA5; in_chan[0] = 2'd2;
    in_valid[1] = 1'b1; in_data[1] = 8'h80; in_chan[1] = 2'd1;
    step();
    in_valid[0] = 1'b0; in_valid[1] = 1'b0;
    repeat (45) step();
    // back-to-back with valid held high
    in_valid[0] = 1'b1; in_data[0] = 8'h01; in_chan[0] = 2'd0;
    step();
    in_data[0] = 8'hFF; in_chan[0] = 2'd3;
    @(negedge clk);
    n = 0;
    while (busy[0] && n < 100) begin n++; @(negedge clk); end
    n = 0;
    while (!busy[0] && n < 10) begin n++; @(negedge clk); end
    check("b2b_gap", n, 1);
    check("b2b_sig", demux_signal[0], 2'd3);
    step();
    in_valid[0] = 1'b0;
    repeat (45) step();
    // random traffic; data and channel keep changing while frames are on the line
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < 2; k++) begin
        in_valid[k] = $urandom_range(0, 3) == 0;
        in_data[k] = DW'($urandom);
        in_chan[k] = 2'($urandom);
      end
      step();
    end
    in_valid[0] = 1'b0; in_valid[1] = 1'b0;
    repeat (45) step();
    // reset during data bit 3
    in_valid[0] = 1'b1; in_data[0] = 8'h08; in_chan[0] = 2'd3;
    step();
    in_valid[0] = 1'b0;
    repeat (16) @(posedge clk);
    #2;
    check("pre_rst_busy", busy[0], 1);
    check("pre_rst_din", demux_in[0], 1);
    rst_n = 1'b0;
    #1;
    check("arst_din", demux_in[0], 0);
    check("arst_busy", busy[0], 0);
    check("arst_sig", demux_signal[0], 0);
    check("arst_ready", in_ready[0], 0);
    repeat (3) step();
    rst_n = 1'b1;
    in_valid[0] = 1'b1; in_data[0] = 8'h3C; in_chan[0] = 2'd1;
    step();
    in_valid[0] = 1'b0;
    @(negedge clk);
    check("post_rst_busy", busy[0], 1);
    repeat (45) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/demux_frame_driver.md
DEMUX_FRAME_DRIVER -- requirements
Module: demux_frame_driver

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4, clock cycles per serial bit, legal range 1..255.
REQ-002 SHALL have parameter DATA_W, default 8, payload bits per frame, legal range 1..16.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1, upstream word available.
REQ-006 SHALL have port in_ready, output, 1, block can accept a word this cycle.
REQ-007 SHALL have port in_data, input, DATA_W, payload word.
REQ-008 SHALL have port in_chan, input, 2, destination channel 0..3.
REQ-009 SHALL have port demux_in, output, 1, serial bit to the downstream 1-to-4 demultiplexer data input.
REQ-010 SHALL have port demux_signal, output, 2, channel select to the downstream demultiplexer.
REQ-011 SHALL have port busy, output, 1, high while a frame is on the line.
REQ-012 SHALL have port frame_done, output, 1, single-cycle pulse at frame end.

Function
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-014 SHALL drive in_ready = 1 only in IDLE; in_ready is 0 in all other states and during reset.
REQ-015 SHALL accept a word on a rising edge where in_valid && in_ready, latching in_data and in_chan, and enter START on that edge.
REQ-016 SHALL ignore in_data, in_chan and in_valid while not in IDLE; a word held valid is accepted on the first IDLE cycle.
REQ-017 SHALL hold each of START, each DATA bit and STOP for exactly CLKS_PER_BIT cycles.
REQ-018 SHALL drive demux_in: 0 in IDLE, 1 in START, latched data LSB-first in DATA, 0 in STOP.
REQ-019 SHALL drive demux_signal from the latched channel, stable for the whole frame, and keep the last channel in IDLE.
REQ-020 SHALL make demux_in, demux_signal, busy and frame_done registered outputs; first START bit appears the cycle after acceptance.
REQ-021 SHALL give frame length (DATA_W+2)*CLKS_PER_BIT cycles, from the first START cycle to the last STOP cycle.
REQ-022 SHALL assert busy in START, DATA and STOP, and deassert it in IDLE.
REQ-023 SHALL pulse frame_done for exactly one cycle: the first IDLE cycle after STOP completes.
REQ-024 SHALL guarantee at least one IDLE cycle between consecutive frames.
REQ-025 SHALL count DATA bits with a counter of width clog2(DATA_W)+1, and the bit-period counter SHALL wrap to 0 at CLKS_PER_BIT-1 without overflow.
REQ-026 SHALL behave correctly with CLKS_PER_BIT = 1: one bit per cycle, no dead cycles within a frame.

Reset
REQ-027 SHALL, on rst_n low, immediately force the following, asynchronously: state IDLE, demux_in 0, demux_signal 2'b00, busy 0, frame_done 0, in_ready 0, all counters and latches 0.
REQ-028 SHALL abort a frame in progress on reset without a frame_done pulse, and SHALL resume normally in IDLE on the first clock edge after rst_n rises.

Structure
REQ-029 SHALL place the FSM state encoding (2-bit: IDLE=0, START=1, DATA=2, STOP=3) and parameter defaults in shared package demux_pkg.
REQ-030 SHALL use one sub-module, bit_timer, a CLKS_PER_BIT-cycle counter with enable, producing a one-cycle bit_tick; it is reset asynchronously by rst_n.

Verification
REQ-031 SHALL verify basic frame: CLKS_PER_BIT=4, in_data=8'hA5, in_chan=2 -> demux_signal=2 for 40 cycles; demux_in = 1 (x4), then 1,0,1,0,0,1,0,1 (x4 each), then 0 (x4); frame_done pulses once.
REQ-032 SHALL verify back-to-back input: in_valid held high with 8'h01/ch0 then 8'hFF/ch3 -> second acceptance occurs exactly 1 IDLE cycle after the first frame ends, and demux_signal switches only at that acceptance.
REQ-033 SHALL verify fastest rate: CLKS_PER_BIT=1, 8'h80/ch1 -> 10-cycle frame 1,0,0,0,0,0,0,0,1,0; busy high for exactly 10 cycles.
REQ-034 SHALL verify reset mid-frame: rst_n low during DATA bit 3 -> same-cycle demux_in=0, busy=0, demux_signal=0; no frame_done; a new word is accepted after release.
REQ-035 SHALL verify input stability: in_data/in_chan toggled every cycle while busy -> serialized bits and channel match the values latched at acceptance; in_ready stays 0 throughout the frame.
